// File: rtl/compare_unit.sv
// compare_unit: multi-cycle RISC-V branch comparator.
// Operands are compared CHUNK bits per cycle, most significant chunk first,
// and the operation exits early at the first differing chunk. Signed
// compares flip the operand MSBs at capture so that every chunk compare
// can be unsigned.
module compare_unit #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic             illegal
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1'b1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [IDXW-1:0]  idx_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       f3_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             result_r;
  logic             illegal_r;
  logic [CHUNK-1:0] a_chunk_s;
  logic [CHUNK-1:0] b_chunk_s;

  // funct3 codes 010 and 011 have no branch meaning
  function automatic logic is_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  // LT and GE compare two's-complement operands
  function automatic logic is_signed_op(input logic [2:0] f3);
    return (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // Map the recorded eq/lt flags onto the requested branch condition
  function automatic logic op_result(input logic [2:0] f3, input logic eq, input logic lt);
    logic r;
    case (f3)
      3'b000:  r = eq;
      3'b001:  r = ~eq;
      3'b100:  r = lt;
      3'b110:  r = lt;
      3'b101:  r = ~lt;
      3'b111:  r = ~lt;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Select the chunk pair currently under comparison
  always_comb begin
    a_chunk_s = a_r[idx_r*CHUNK +: CHUNK];
    b_chunk_s = b_r[idx_r*CHUNK +: CHUNK];
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= IDX_TOP;
      a_r         <= '0;
      b_r         <= '0;
      f3_r        <= 3'b000;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (flush) begin
      state_r     <= ST_IDLE;
      idx_r       <= IDX_TOP;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= 1'b0;
      illegal_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r        <= is_signed_op(funct3) ? (a ^ MSB_MASK) : a;
            b_r        <= is_signed_op(funct3) ? (b ^ MSB_MASK) : b;
            f3_r       <= funct3;
            idx_r      <= IDX_TOP;
            in_ready_r <= 1'b0;
            result_r   <= 1'b0;
            if (is_illegal(funct3)) begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b1;
              illegal_r   <= 1'b1;
            end else begin
              state_r     <= ST_BUSY;
              out_valid_r <= 1'b0;
              illegal_r   <= 1'b0;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (a_chunk_s != b_chunk_s) begin
            // early exit: the first differing chunk decides the order
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            result_r    <= op_result(f3_r, 1'b0, a_chunk_s < b_chunk_s);
          end else if (idx_r == '0) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            result_r    <= op_result(f3_r, 1'b1, 1'b0);
          end else begin
            idx_r <= idx_r - IDXW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            idx_r       <= IDX_TOP;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= 1'b0;
            illegal_r   <= 1'b0;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          idx_r       <= IDX_TOP;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          result_r    <= 1'b0;
          illegal_r   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_compare_unit.sv
// Self-checking bench for compare_unit (WIDTH=64, CHUNK=16): a vector table
// of directed cases, a block of random cases against a reference model,
// and hand-written reset / flush / hold sequences.
module tb_compare_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [2:0]  funct3;
  logic        out_valid;
  logic        out_ready;
  logic        result;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] va;
    logic [63:0] vb;
    logic [2:0]  f3;
    logic        res;
    logic        ill;
    int          lat;
  } vec_t;

  typedef struct {
    logic res;
    logic ill;
    int   lat;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[14];

  compare_unit #(.WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .funct3(funct3),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: direct signed/unsigned compares, plus chunk count to first difference
  function automatic exp_t model(input logic [63:0] va, input logic [63:0] vb, input logic [2:0] f3);
    exp_t e;
    logic lt_s, lt_u, eq;
    int k;
    lt_s = $signed(va) < $signed(vb);
    lt_u = va < vb;
    eq   = (va == vb);
    k = 0;
    for (int i = 3; i >= 0; i--) begin
      k++;
      if (va[i*16 +: 16] != vb[i*16 +: 16]) break;
    end
    e.ill = 1'b0;
    e.lat = k + 1;
    case (f3)
      3'b000: e.res = eq;
      3'b001: e.res = ~eq;
      3'b100: e.res = lt_s;
      3'b101: e.res = ~lt_s;
      3'b110: e.res = lt_u;
      3'b111: e.res = ~lt_u;
      default: begin e.res = 1'b0; e.ill = 1'b1; e.lat = 1; end
    endcase
    return e;
  endfunction

  // Drive one request, push its expectation, wait for the result and compare
  task automatic run_op(input logic [63:0] va, input logic [63:0] vb, input logic [2:0] vf,
                        input logic er, input logic ei, input int el, input int hold);
    exp_t e, got;
    int cnt;
    @(negedge clk);
    a = va; b = vb; funct3 = vf; in_valid = 1'b1;
    check("in_ready_idle", in_ready, 64'd1);
    e.res = er; e.ill = ei; e.lat = el;
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom}; funct3 = 3'($urandom);
    cnt = 1;
    while (!out_valid && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    got = sb_q.pop_front();
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: out_valid never rose, expected after %0d cycles", got.lat);
    end else begin
      check("result", result, 64'(got.res));
      check("illegal", illegal, 64'(got.ill));
      check("latency", 64'(cnt), 64'(got.lat));
      check("in_ready_done", in_ready, 64'd0);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_valid", out_valid, 64'd1);
        check("hold_result", result, 64'(got.res));
        check("hold_illegal", illegal, 64'(got.ill));
        check("hold_in_ready", in_ready, 64'd0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("ret_valid", out_valid, 64'd0);
    check("ret_in_ready", in_ready, 64'd1);
  endtask

  initial begin
    exp_t e;
    logic [63:0] ra, rb;
    logic [2:0] rf;
    logic [2:0] legal_f3 [6];
    legal_f3 = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

    tbl[0]  = '{64'd5, 64'd7, 3'b110, 1'b1, 1'b0, 5};
    tbl[1]  = '{64'h8000_0000_0000_0000, 64'd1, 3'b100, 1'b1, 1'b0, 2};
    tbl[2]  = '{64'h8000_0000_0000_0000, 64'd1, 3'b110, 1'b0, 1'b0, 2};
    tbl[3]  = '{64'h8000_0000_0000_0000, 64'd1, 3'b101, 1'b0, 1'b0, 2};
    tbl[4]  = '{64'hDEAD_BEEF_0000_1234, 64'hDEAD_BEEF_0000_1234, 3'b000, 1'b1, 1'b0, 5};
    tbl[5]  = '{64'hDEAD_BEEF_0000_1234, 64'hDEAD_BEEF_0000_1234, 3'b001, 1'b0, 1'b0, 5};
    tbl[6]  = '{64'hDEAD_BEEF_0000_1234, 64'hDEAD_BEEF_0000_1234, 3'b111, 1'b1, 1'b0, 5};
    tbl[7]  = '{64'd3, 64'd9, 3'b010, 1'b0, 1'b1, 1};
    tbl[8]  = '{64'd3, 64'd3, 3'b011, 1'b0, 1'b1, 1};
    tbl[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 3'b100, 1'b1, 1'b0, 2};
    tbl[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 3'b111, 1'b1, 1'b0, 2};
    tbl[11] = '{64'h0000_0000_0001_0000, 64'h0000_0000_0000_FFFF, 3'b101, 1'b1, 1'b0, 4};
    tbl[12] = '{64'h0000_0000_0001_0000, 64'h0000_0000_0000_FFFF, 3'b100, 1'b0, 1'b0, 4};
    tbl[13] = '{64'd1, 64'd0, 3'b001, 1'b1, 1'b0, 5};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; funct3 = 3'b000;
    #12;
    check("rst_in_ready", in_ready, 64'd1);
    check("rst_out_valid", out_valid, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_illegal", illegal, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed table; the first entry also checks accept right after reset release
    for (int i = 0; i < 14; i++)
      run_op(tbl[i].va, tbl[i].vb, tbl[i].f3, tbl[i].res, tbl[i].ill, tbl[i].lat, 0);

    // result hold while consumer stalls
    run_op(64'd5, 64'd7, 3'b110, 1'b1, 1'b0, 5, 3);
    run_op(64'd4, 64'd4, 3'b010, 1'b0, 1'b1, 1, 3);

    // random operations checked against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0:       rb = {$urandom, $urandom};
        1:       rb = ra;
        default: rb = ra ^ (64'($urandom_range(1, 65535)) << (16 * $urandom_range(0, 3)));
      endcase
      rf = legal_f3[$urandom_range(0, 5)];
      e = model(ra, rb, rf);
      run_op(ra, rb, rf, e.res, e.ill, e.lat, 0);
    end

    // async reset during the second BUSY cycle drops the operation
    @(negedge clk);
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h1234_5678_9ABC_DEF0; funct3 = 3'b000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 64'd1);
    check("midrst_out_valid", out_valid, 64'd0);
    check("midrst_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_valid", out_valid, 64'd0);
    end
    run_op(64'd100, 64'd50, 3'b111, 1'b1, 1'b0, 5, 0);

    // flush in BUSY with a competing request that must be ignored
    @(negedge clk);
    a = 64'hAAAA_0000_0000_0000; b = 64'hAAAA_0000_0000_0000; funct3 = 3'b000; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b1; funct3 = 3'b010; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_in_ready", in_ready, 64'd1);
    check("flush_out_valid", out_valid, 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("flush_no_valid", out_valid, 64'd0);
      check("flush_idle", in_ready, 64'd1);
    end

    // flush in DONE discards the pending result
    @(negedge clk);
    a = 64'd1; b = 64'd2; funct3 = 3'b011; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_flush_done", out_valid, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_done_valid", out_valid, 64'd0);
    check("flush_done_illegal", illegal, 64'd0);
    check("flush_done_ready", in_ready, 64'd1);
    run_op(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 1'b1, 1'b0, 5, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/compare_unit.md
COMPARE_UNIT -- requirements
Module: compare_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 16, bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK, and CHUNK SHALL be at least 1.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  reset; one clock, reset asynchronous, active-low.
REQ-005 Port: flush  input  1  synchronous abort of any operation in progress.
REQ-006 Port: in_valid  input  1  request valid.
REQ-007 Port: in_ready  output  1  unit can accept a request.
REQ-008 Port: a  input  WIDTH  operand A.
REQ-009 Port: b  input  WIDTH  operand B.
REQ-010 Port: funct3  input  3  RISC-V branch encoding: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
REQ-011 Port: out_valid  output  1  result valid.
REQ-012 Port: out_ready  input  1  consumer accepts result.
REQ-013 Port: result  output  1  comparison outcome.
REQ-014 Port: illegal  output  1  funct3 was 010 or 011.

Function
REQ-015 SHALL implement FSM IDLE, BUSY, DONE; NCHUNK = WIDTH/CHUNK.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept on in_valid && in_ready: register a, b, funct3; legal funct3 -> BUSY with chunk index idx = NCHUNK-1; illegal -> DONE with result=0, illegal=1.
REQ-018 Signed ops (LT, GE): MSB of both captured operands SHALL be inverted at capture, so that all chunk compares are unsigned.
REQ-019 Each BUSY cycle SHALL compare chunk [idx*CHUNK +: CHUNK] of both operands, proceeding from MSB to LSB.
REQ-020 If the chunks differ: record lt = (a_chunk < b_chunk), record eq = 0, and go to DONE (early exit).
REQ-021 If the chunks are equal and idx == 0: record eq = 1, record lt = 0, and go to DONE; otherwise decrement idx and remain in BUSY.
REQ-022 Result in DONE: EQ=eq, NE=~eq, LT/LTU=lt, GE/GEU=~lt; illegal=0 for legal ops.
REQ-023 Latency: out_valid SHALL rise k+1 cycles after the accept edge, where k = number of chunks examined (1..NCHUNK); for illegal ops it SHALL rise 1 cycle after the accept edge.
REQ-024 In DONE, result and illegal SHALL hold stable while out_ready=0; on out_ready=1 -> IDLE, with out_valid=0 next cycle.
REQ-025 No result SHALL be accepted in the same cycle as a new request (in_ready=0 in DONE); throughput is at most one operation per k+2 cycles.
REQ-026 flush=1 SHALL force IDLE on the next edge from any state, discard the pending result, and ignore in_valid in that cycle; flush has priority over all other transitions.
REQ-027 Operand inputs SHALL be don't-care outside the accept cycle.

Reset
REQ-028 While rst_n=0, state SHALL be IDLE, in_ready=1, out_valid=0, result=0, illegal=0, and idx=NCHUNK-1; this takes effect immediately, independent of clk.
REQ-029 Reset asserted mid-BUSY or mid-DONE SHALL drop the operation with no out_valid pulse after release.
REQ-030 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Verification (WIDTH=64, CHUNK=16)
REQ-031 a=5, b=7, funct3=110 (LTU) -> 4 BUSY cycles, out_valid 5 cycles after accept, result=1.
REQ-032 a=0x8000_0000_0000_0000, b=1: LT -> result=1 after 1 BUSY cycle; LTU -> result=0 after 1 BUSY cycle; GE -> result=0.
REQ-033 a=b=0xDEAD_BEEF_0000_1234: EQ -> result=1 after 4 BUSY cycles; NE -> result=0; GEU -> result=1.
REQ-034 Hold out_ready=0 for 3 cycles in DONE -> out_valid, result, illegal stable, in_ready=0; then out_ready=1 -> IDLE with in_ready=1 next cycle.
REQ-035 funct3=010 -> out_valid 1 cycle after accept, illegal=1, result=0.
REQ-036 rst_n pulse low during the 2nd BUSY cycle, and separately flush=1 in BUSY -> IDLE, out_valid never asserts for that operation, and a following request completes correctly.
